// File: rtl/viterbi_pkg.sv
// Constants and helpers shared by the K=7 convolutional encoder and the Viterbi
// decoder blocks (bmc/acs/traceback).
package viterbi_pkg;

  localparam int K          = 7;
  localparam int NUM_STATES = 64;
  localparam int TAIL_LEN   = K - 1;

  localparam logic [6:0] G0_DEF = 7'o171;
  localparam logic [6:0] G1_DEF = 7'o133;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    TAIL = 2'd2
  } enc_state_e;

  // Bit 6 of the window is the bit being encoded, bit 0 the oldest past bit.
  function automatic logic gen_parity(input logic [6:0] w, input logic [6:0] g);
    return ^(w & g);
  endfunction

endpackage

// File: rtl/conv_encoder_k7_if.sv
// Stream handshake bundle for the convolutional encoder: serial info bits in,
// 2-bit code symbols out.
interface conv_encoder_k7_if;

  logic       in_valid;
  logic       in_ready;
  logic       in_bit;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_sym;
  logic       out_last;
  logic       out_tail;

  modport slave (
    input  in_valid, in_bit, in_last, out_ready,
    output in_ready, out_valid, out_sym, out_last, out_tail
  );

  modport master (
    output in_valid, in_bit, in_last, out_ready,
    input  in_ready, out_valid, out_sym, out_last, out_tail
  );

endinterface

// File: rtl/conv_parity.sv
// Combinational symbol generator: one XOR-reduced parity bit per generator
// polynomial over the 7-bit encoding window.
module conv_parity
  import viterbi_pkg::*;
#(
  parameter logic [6:0] G0 = G0_DEF,
  parameter logic [6:0] G1 = G1_DEF
) (
  input  logic [6:0] w,
  output logic [1:0] sym
);

  // sym[1] pairs with rx_pair[1] in the decoder.
  assign sym = {gen_parity(w, G1), gen_parity(w, G0)};

endmodule

// File: rtl/conv_encoder_k7.sv
// Rate-1/2, K=7 convolutional encoder with optional zero-tail termination and a
// single-register output stage under valid/ready flow control.
module conv_encoder_k7 #(
  parameter int         K         = 7,
  parameter logic [6:0] G0        = viterbi_pkg::G0_DEF,
  parameter logic [6:0] G1        = viterbi_pkg::G1_DEF,
  parameter bit         TERMINATE = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  conv_encoder_k7_if.slave        bus,
  output logic                    busy
);

  localparam int SR_W = K - 1;
  localparam logic [2:0] LAST_TAIL_CNT = 3'(SR_W - 1);

  localparam logic [1:0] ST_IDLE = viterbi_pkg::IDLE;
  localparam logic [1:0] ST_DATA = viterbi_pkg::DATA;
  localparam logic [1:0] ST_TAIL = viterbi_pkg::TAIL;

  logic [1:0]      state;
  logic [2:0]      tail_cnt;
  logic [SR_W-1:0] sr;

  logic            slot_free;
  logic            accept;
  logic            tail_step;
  logic            enc_bit;
  logic [K-1:0]    window;
  logic [1:0]      sym;

  assign slot_free    = !bus.out_valid || bus.out_ready;
  // Gated by rst_n so nothing upstream sees a ready during the reset cycle.
  assign bus.in_ready = rst_n && (state != ST_TAIL) && slot_free;
  assign accept       = bus.in_valid && bus.in_ready;
  assign tail_step    = (state == ST_TAIL) && slot_free;
  assign busy         = (state != ST_IDLE) || bus.out_valid;

  // Select the bit entering the window: zero while flushing, else the info bit.
  always_comb begin
    enc_bit = 1'b0;
    if (tail_step) begin
      enc_bit = 1'b0;
    end else begin
      enc_bit = bus.in_bit;
    end
  end

  assign window = {enc_bit, sr};

  conv_parity #(
    .G0 (G0),
    .G1 (G1)
  ) u_parity (
    .w   (window),
    .sym (sym)
  );

  // Shift register, frame FSM, tail counter and the output symbol register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr            <= '0;
      state         <= ST_IDLE;
      tail_cnt      <= 3'd0;
      bus.out_valid <= 1'b0;
      bus.out_sym   <= 2'b00;
      bus.out_last  <= 1'b0;
      bus.out_tail  <= 1'b0;
    end else if (accept) begin
      sr            <= {enc_bit, sr[SR_W-1:1]};
      bus.out_sym   <= sym;
      bus.out_valid <= 1'b1;
      bus.out_tail  <= 1'b0;
      bus.out_last  <= bus.in_last && !TERMINATE;
      tail_cnt      <= 3'd0;
      if (bus.in_last) begin
        state <= TERMINATE ? ST_TAIL : ST_IDLE;
      end else begin
        state <= ST_DATA;
      end
    end else if (tail_step) begin
      sr            <= {enc_bit, sr[SR_W-1:1]};
      bus.out_sym   <= sym;
      bus.out_valid <= 1'b1;
      bus.out_tail  <= 1'b1;
      if (tail_cnt == LAST_TAIL_CNT) begin
        bus.out_last <= 1'b1;
        tail_cnt     <= 3'd0;
        state        <= ST_IDLE;
      end else begin
        bus.out_last <= 1'b0;
        tail_cnt     <= tail_cnt + 3'd1;
        state        <= state;
      end
    end else if (slot_free) begin
      // Symbol consumed with nothing new to load: drop valid, keep payload.
      bus.out_valid <= 1'b0;
    end else begin
      bus.out_valid <= bus.out_valid;
    end
  end

endmodule

// File: tb/tb_conv_encoder_k7.sv
// Directed self-checking bench for conv_encoder_k7 (terminated and
// unterminated instances) with a symbol collector and hold checker.
module tb_conv_encoder_k7;

  logic clk = 1'b0;
  logic rst_n;
  logic busy;
  logic busy2;

  always #5 clk = ~clk;

  conv_encoder_k7_if bus ();
  conv_encoder_k7_if bus2 ();

  conv_encoder_k7 #(.TERMINATE(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  conv_encoder_k7 #(.TERMINATE(1'b0)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2),
    .busy  (busy2)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int rdy_mode = 0;
  int stall_cnt = 0;

  logic [1:0] col_sym[$];
  logic       col_last[$];
  logic       col_tail[$];
  int         col_cyc[$];
  logic [1:0] exp_sym[$];
  logic       exp_last[$];
  logic       exp_tail[$];

  logic [1:0] imp[7]     = '{2'b11, 2'b01, 2'b11, 2'b11, 2'b00, 2'b10, 2'b11};
  logic       rdy_pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Downstream ready: always high, or the 1,0,0,1 pattern.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 1) bus.out_ready = rdy_pat[cyc % 4];
      else               bus.out_ready = 1'b1;
    end
  end

  // Records every handshaken symbol; checks hold and in_ready while stalled.
  initial begin
    logic [1:0] h_sym;
    logic       h_last;
    logic       h_tail;
    logic       stall_prev;
    stall_prev = 1'b0;
    h_sym = 2'b00; h_last = 1'b0; h_tail = 1'b0;
    forever begin
      @(negedge clk);
      if (stall_prev && rst_n) begin
        check_eq("hold_sym",  int'(bus.out_sym),  int'(h_sym));
        check_eq("hold_last", int'(bus.out_last), int'(h_last));
        check_eq("hold_tail", int'(bus.out_tail), int'(h_tail));
      end
      stall_prev = 1'b0;
      if (rst_n && bus.out_valid) begin
        if (bus.out_ready) begin
          col_sym.push_back(bus.out_sym);
          col_last.push_back(bus.out_last);
          col_tail.push_back(bus.out_tail);
          col_cyc.push_back(cyc);
        end else begin
          check_eq("stall_in_ready", int'(bus.in_ready), 0);
          stall_cnt++;
          stall_prev = 1'b1;
          h_sym = bus.out_sym; h_last = bus.out_last; h_tail = bus.out_tail;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive_frame(input int n, input logic [31:0] bits);
    for (int i = 0; i < n; i++) begin
      int waited;
      waited = 0;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_bit   = bits[i];
      bus.in_last  = (i == n - 1);
      while (!bus.in_ready && waited < 100) begin
        @(negedge clk);
        waited++;
      end
      check_eq("accept_bound", int'(waited < 100), 1);
      @(posedge clk);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_bit   = 1'b0;
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    @(negedge clk);
    while (busy && w < 200) begin
      @(negedge clk);
      w++;
    end
    check_eq("idle_bound", int'(busy), 0);
  endtask

  task automatic push_impulse();
    for (int i = 0; i < 7; i++) begin
      exp_sym.push_back(imp[i]);
      exp_last.push_back(i == 6);
      exp_tail.push_back(i > 0);
    end
  endtask

  task automatic compare_frame(input string name, input bit contiguous);
    check_eq({name, "_count"}, col_sym.size(), exp_sym.size());
    for (int i = 0; i < exp_sym.size() && i < col_sym.size(); i++) begin
      check_eq($sformatf("%s_sym%0d", name, i),  int'(col_sym[i]),  int'(exp_sym[i]));
      check_eq($sformatf("%s_last%0d", name, i), int'(col_last[i]), int'(exp_last[i]));
      check_eq($sformatf("%s_tail%0d", name, i), int'(col_tail[i]), int'(exp_tail[i]));
      if (contiguous && i > 0)
        check_eq($sformatf("%s_gap%0d", name, i), col_cyc[i] - col_cyc[i-1], 1);
    end
    col_sym.delete(); col_last.delete(); col_tail.delete(); col_cyc.delete();
    exp_sym.delete(); exp_last.delete(); exp_tail.delete();
  endtask

  initial begin
    int w;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;  bus.in_bit = 1'b0;  bus.in_last = 1'b0;
    bus2.in_valid = 1'b0; bus2.in_bit = 1'b0; bus2.in_last = 1'b0;
    bus2.out_ready = 1'b1;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_valid",    int'(bus.out_valid), 0);
    check_eq("rst_sym",      int'(bus.out_sym),   0);
    check_eq("rst_last",     int'(bus.out_last),  0);
    check_eq("rst_tail",     int'(bus.out_tail),  0);
    check_eq("rst_busy",     int'(busy),          0);
    check_eq("rst_in_ready", int'(bus.in_ready),  0);
    check_eq("rst2_valid",   int'(bus2.out_valid), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("idle_in_ready", int'(bus.in_ready), 1);

    // Impulse response, full throughput
    push_impulse();
    drive_frame(1, 32'h1);
    wait_idle();
    compare_frame("impulse", 1'b1);

    // All-zero frame of 8 bits
    for (int i = 0; i < 14; i++) begin
      exp_sym.push_back(2'b00);
      exp_last.push_back(i == 13);
      exp_tail.push_back(i >= 8);
    end
    drive_frame(8, 32'h0);
    wait_idle();
    compare_frame("zeros", 1'b1);

    // Backpressure with ready pattern 1,0,0,1
    rdy_mode = 1;
    stall_cnt = 0;
    push_impulse();
    drive_frame(1, 32'h1);
    wait_idle();
    compare_frame("bp", 1'b0);
    check_eq("bp_stalls_seen", int'(stall_cnt > 0), 1);
    rdy_mode = 0;
    @(negedge clk);

    // Back-to-back single-bit frames
    push_impulse();
    push_impulse();
    drive_frame(1, 32'h1);
    drive_frame(1, 32'h1);
    wait_idle();
    compare_frame("b2b", 1'b1);

    // Reset during the tail, after the 3rd tail symbol
    drive_frame(1, 32'h1);
    w = 0;
    while (col_sym.size() < 4 && w < 50) begin
      @(negedge clk);
      #1;
      w++;
    end
    check_eq("midtail_reached", col_sym.size(), 4);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_eq("mrst_valid",    int'(bus.out_valid), 0);
    check_eq("mrst_sym",      int'(bus.out_sym),   0);
    check_eq("mrst_last",     int'(bus.out_last),  0);
    check_eq("mrst_tail",     int'(bus.out_tail),  0);
    check_eq("mrst_busy",     int'(busy),          0);
    check_eq("mrst_in_ready", int'(bus.in_ready),  0);
    rst_n = 1'b1;
    col_sym.delete(); col_last.delete(); col_tail.delete(); col_cyc.delete();
    push_impulse();
    drive_frame(1, 32'h1);
    wait_idle();
    compare_frame("post_rst", 1'b1);

    // Unterminated encoder: two 1-bit frames share the shift register
    @(negedge clk);
    bus2.in_valid = 1'b1; bus2.in_bit = 1'b1; bus2.in_last = 1'b1;
    check_eq("nt_in_ready", int'(bus2.in_ready), 1);
    @(posedge clk);
    @(negedge clk);
    check_eq("nt0_valid", int'(bus2.out_valid), 1);
    check_eq("nt0_sym",   int'(bus2.out_sym),   3);
    check_eq("nt0_last",  int'(bus2.out_last),  1);
    check_eq("nt0_tail",  int'(bus2.out_tail),  0);
    check_eq("nt0_in_ready", int'(bus2.in_ready), 1);
    @(posedge clk);
    @(negedge clk);
    check_eq("nt1_valid", int'(bus2.out_valid), 1);
    check_eq("nt1_sym",   int'(bus2.out_sym),   2);
    check_eq("nt1_last",  int'(bus2.out_last),  1);
    check_eq("nt1_tail",  int'(bus2.out_tail),  0);
    bus2.in_valid = 1'b0; bus2.in_last = 1'b0; bus2.in_bit = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_eq("nt_done_valid", int'(bus2.out_valid), 0);
    check_eq("nt_done_busy",  int'(busy2),          0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_encoder_k7.md
Name: conv_encoder_k7

Overview:
Rate-1/2, constraint-length-7 (64-state) convolutional encoder. It is the transmit-side counterpart of the Viterbi decoder's branch-metric/ACS datapath. It accepts a framed serial bit stream and emits one 2-bit code symbol per info bit. The symbol uses the same bit ordering the decoder's rx_pair input expects. With termination enabled, it appends K-1 zero tail bits per frame so the decoder's traceback ends in state 0.

Parameters:
K, 7, constraint length; shift register holds K-1 = 6 past bits
G0, 7'o171, generator polynomial for sym[0]; bit 6 taps the current input bit, bit 0 taps the oldest bit
G1, 7'o133, generator polynomial for sym[1]; same tap ordering as G0
TERMINATE, 1, 1 = append K-1 zero tail bits after in_last; 0 = no tail, register carries over between frames

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous, active-low reset
in_valid  in  1  info bit valid
in_ready  out  1  encoder can accept an info bit this cycle
in_bit  in  1  info bit
in_last  in  1  qualifies in_bit as the final info bit of the frame
out_valid  out  1  code symbol valid
out_ready  in  1  downstream accepts the symbol
out_sym  out  2  {parity_G1, parity_G0}; same ordering as rx_pair[1:0]
out_last  out  1  final symbol of the frame (last tail symbol, or last info symbol when TERMINATE=0)
out_tail  out  1  current symbol is a tail symbol
busy  out  1  state != IDLE or out_valid

Behaviour:
- Encoding window: w[6:0] = {b, sr[5:0]}, where b is the bit being encoded and sr[5] is the most recent past bit.
- sym[i] = ^(w & Gi), i.e. XOR reduction. After encoding, sr <= {b, sr[5:1]}.
- Reset (rst_n=0 at a clk edge) forces: sr=0, state=IDLE, tail_cnt=0, out_valid=0, out_sym=0, out_last=0, out_tail=0, busy=0, in_ready=0 in the reset cycle.
- Reset mid-frame abandons the frame with no flush; the first symbol after reset starts from sr=0.
- States:
  - IDLE: no frame open.
  - DATA: frame open.
  - TAIL: emitting tail.
- Output stage is a single register. "Slot free" = !out_valid || out_ready.
- in_ready = (state != TAIL) && slot free. It is combinational from out_ready.
- Input accept (in_valid && in_ready):
  - Encode in_bit and load out_sym/out_valid on the next edge. Latency is 1 cycle from accept to out_valid.
  - out_tail = 0.
  - out_last = in_last && !TERMINATE.
- Transitions:
  - IDLE -> DATA on an accept with !in_last.
  - IDLE/DATA -> TAIL on an accept with in_last, when TERMINATE=1.
  - IDLE/DATA -> IDLE on an accept with in_last, when TERMINATE=0.
- In TAIL, each cycle the slot is free:
  - Encode b = 0, increment tail_cnt, set out_tail = 1.
  - On the 6th tail symbol (tail_cnt == 5 before the increment): out_last = 1, tail_cnt -> 0, state -> IDLE.
  - After the tail, sr == 0 by construction.
- Throughput is one symbol per cycle when out_ready is held high. A single-bit frame yields 7 symbols.
- Backpressure: when out_valid && !out_ready, out_sym, out_last and out_tail hold stable. sr, state and tail_cnt do not advance.
- Back-to-back frames: a new frame's first bit is accepted the cycle after the last tail symbol is loaded. There are no bubbles beyond the tail.
- in_valid while in TAIL is ignored (in_ready = 0); it is not a protocol error.
- When TERMINATE=0, sr persists across frames and is cleared only by reset.

Decomposition:
- Package viterbi_pkg holds:
  - K, NUM_STATES = 64
  - G0_DEF = 7'o171, G1_DEF = 7'o133
  - TAIL_LEN = K-1
  - state enum {IDLE, DATA, TAIL}
  - These constants are shared with the decoder's bmc/acs/traceback blocks.
- Sub-module conv_parity (combinational): inputs w[6:0], outputs the 2-bit symbol. It is instantiated once and reused for any future puncturing variant.

Test Plan:
- Impulse: reset, then a frame of the single bit 1 with in_last, out_ready=1 -> out_sym sequence 11,01,11,11,00,10,11. out_tail = 0 on the first symbol and 1 on the rest. out_last only on the 7th symbol. busy drops afterwards.
- All-zero frame of 8 bits -> 14 symbols, all 00. out_last on the 14th symbol.
- Backpressure: same impulse frame with out_ready toggled 1,0,0,1,... -> identical symbol sequence. Symbols stay stable while stalled. in_ready = 0 whenever out_valid && !out_ready.
- Back-to-back: frame A = {1} immediately followed by frame B = {1} -> 14 symbols = two copies of the impulse response. B's first symbol arrives in the cycle after A's out_last, with no extra gaps.
- Reset mid-TAIL: after the 3rd tail symbol, assert rst_n=0 for one cycle -> all outputs return to reset values. A following impulse frame reproduces 11,01,11,11,00,10,11.
- TERMINATE=0: two consecutive 1-bit frames {1},{1} -> symbols 11, then 10 (w = 1100000), each with out_last=1 and out_tail=0.
